// File: rtl/edge_frame_writer.sv
// Packs binarised edge pixels into PACK_W-bit words and writes one frame per frame_start.
// Optional per-frame edge pixel counter is enabled by EDGE_WRITER_COUNT_EN.
module edge_frame_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int PACK_W   = 8,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [11:0]       datain,
    input  logic              datain_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PACK_W-1:0] wr_data,
    output logic              frame_done,
    output logic              frame_abort,
    output logic [19:0]       edge_count
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BW = (PACK_W > 1) ? $clog2(PACK_W) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(PACK_W - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state_q, state_d;

    logic [BW-1:0]     bit_cnt, bc;
    logic [XW-1:0]     x, xc;
    logic [YW-1:0]     y, yc;
    logic [ADDR_W-1:0] word_addr, wa;
    logic [PACK_W-1:0] pack, pk, pack_next;
    logic              run, pix, acc, last_px, restart;
    logic              word_done, frame_last;

    // A frame_start that coincides with the final pixel closes the old frame
    // first, so only a non-final frame_start restarts the counters.
    always_comb begin
        run        = (state_q == RUN);
        pix        = |datain;
        last_px    = run && datain_en && (bit_cnt == B_LAST)
                     && (x == X_LAST) && (y == Y_LAST);
        restart    = frame_start && !last_px;
        acc        = datain_en && (run || frame_start);
        bc         = restart ? '0 : bit_cnt;
        xc         = restart ? '0 : x;
        yc         = restart ? '0 : y;
        wa         = restart ? '0 : word_addr;
        pk         = restart ? '0 : pack;
        pack_next  = pk | (PACK_W'(pix) << bc);
        word_done  = acc && (bc == B_LAST);
        frame_last = word_done && (xc == X_LAST) && (yc == Y_LAST);
    end

    always_comb begin
        state_d = state_q;
        if (frame_last) begin
            state_d = frame_start ? RUN : IDLE;
        end else if (frame_start) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_cnt     <= '0;
            x           <= '0;
            y           <= '0;
            word_addr   <= '0;
            pack        <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_en       <= word_done;
            frame_done  <= frame_last;
            frame_abort <= run && restart;
            bit_cnt     <= bc;
            x           <= xc;
            y           <= yc;
            word_addr   <= wa;
            pack        <= pk;
            if (acc) begin
                if (word_done) begin
                    bit_cnt   <= '0;
                    pack      <= '0;
                    wr_addr   <= wa;
                    wr_data   <= pack_next;
                    word_addr <= frame_last ? '0 : wa + ADDR_W'(1);
                end else begin
                    bit_cnt <= bc + BW'(1);
                    pack    <= pack_next;
                end
                if (xc == X_LAST) begin
                    x <= '0;
                    y <= (yc == Y_LAST) ? '0 : yc + YW'(1);
                end else begin
                    x <= xc + XW'(1);
                end
            end
        end
    end

`ifdef EDGE_WRITER_COUNT_EN
    logic [19:0] ec_cnt, ec;

    always_comb begin
        ec = restart ? '0 : ec_cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ec_cnt     <= '0;
            edge_count <= '0;
        end else if (frame_last) begin
            ec_cnt     <= '0;
            edge_count <= ec + 20'(pix);
        end else if (acc) begin
            ec_cnt <= ec + 20'(pix);
        end else begin
            ec_cnt <= ec;
        end
    end
`else
    assign edge_count = '0;
`endif

endmodule

// File: tb/tb_edge_frame_writer.sv
// Self-checking bench for edge_frame_writer (16x2 frame, 8 pixels per word).
module tb_edge_frame_writer;

    localparam int H  = 16;
    localparam int V  = 2;
    localparam int P  = 8;
    localparam int AW = 16;
`ifdef EDGE_WRITER_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame_start = 1'b0;
    logic [11:0]   datain = '0;
    logic          datain_en = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [P-1:0]  wr_data;
    logic          frame_done;
    logic          frame_abort;
    logic [19:0]   edge_count;

    edge_frame_writer #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .PACK_W(P),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_start(frame_start),
        .datain(datain),
        .datain_en(datain_en),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .frame_done(frame_done),
        .frame_abort(frame_abort),
        .edge_count(edge_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        done;
        int          cyc;
    } exp_t;

    typedef struct {
        int          kind;
        int          gap;
        logic [31:0] words;
        int          edges;
    } vec_t;

    exp_t q[$];
    vec_t tbl[4];
    int   n_tests = 0;
    int   n_fail = 0;
    int   abort_seen = 0;

    function automatic logic [31:0] ec(input int e);
        return CNT_EN ? 32'(e) : 32'd0;
    endfunction

    function automatic logic [11:0] pat(input int kind, input int i);
        case (kind)
            0: return (i % 2 == 0) ? 12'hfff : 12'h000;
            1: return (i == 0) ? 12'hfff : 12'h000;
            2: return 12'hfff;
            3: return (i % 8 == 7) ? 12'h001 : 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (frame_abort) abort_seen++;
        if (frame_done && !wr_en) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_without_write at cyc %0d", cyc);
        end
        if (wr_en) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %h cyc %0d",
                         wr_addr, wr_data, cyc);
            end else begin
                e = q.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data ||
                    frame_done !== e.done || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL write: got a=%0d d=%h done=%b cyc=%0d expected a=%0d d=%h done=%b cyc=%0d",
                             wr_addr, wr_data, frame_done, cyc,
                             e.addr, e.data, e.done, e.cyc);
                end
            end
        end
    endtask

    task automatic send(input logic [11:0] d, input logic fs, input logic en,
                        input logic rs, input bit push, input logic [15:0] a,
                        input logic [7:0] w, input logic dn);
        exp_t e;
        @(negedge clk);
        monitor();
        rst         = rs;
        frame_start = fs;
        datain      = d;
        datain_en   = en;
        if (push) begin
            e.addr = a;
            e.data = w;
            e.done = dn;
            e.cyc  = cyc + 1;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            send(12'habc, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic fs_pulse();
        send(12'h000, 1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic frame(input int kind, input int gap, input logic [31:0] words,
                         input int fs_idx, input int npix);
        logic [7:0] w;
        for (int i = 0; i < npix; i++) begin
            w = words[8*(i/8) +: 8];
            send(pat(kind, i), i == fs_idx, 1'b1, 1'b1, (i % 8) == 7,
                 16'(i / 8), w, i == 31);
            if (gap != 0) idle(1);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_frame_abort"}, 32'(frame_abort), 32'd0);
        chk({tag, "_edge_count"}, 32'(edge_count), 32'd0);
    endtask

    initial begin
        tbl[0] = '{kind: 0, gap: 0, words: 32'h55555555, edges: 16};
        tbl[1] = '{kind: 1, gap: 1, words: 32'h00000001, edges: 1};
        tbl[2] = '{kind: 2, gap: 0, words: 32'hffffffff, edges: 32};
        tbl[3] = '{kind: 3, gap: 0, words: 32'h80808080, edges: 4};

        for (int i = 0; i < 3; i++)
            send(12'hfff, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(1);
        chk_reset_outputs("reset");

        for (int i = 0; i < 10; i++)
            send(12'hfff, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        idle(2);

        for (int v = 0; v < 4; v++) begin
            fs_pulse();
            frame(tbl[v].kind, tbl[v].gap, tbl[v].words, -1, 32);
            idle(3);
            for (int i = 0; i < 8; i++)
                send(12'hfff, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
            idle(2);
            chk("vec_drain", 32'(q.size()), 32'd0);
            chk("vec_edge_count", 32'(edge_count), ec(tbl[v].edges));
        end

        fs_pulse();
        frame(0, 0, 32'h55555555, -1, 12);
        frame(2, 0, 32'hffffffff, 0, 32);
        idle(3);
        chk("abort_drain", 32'(q.size()), 32'd0);
        chk("abort_count", 32'(abort_seen), 32'd1);
        chk("abort_edge_count", 32'(edge_count), ec(32));

        fs_pulse();
        frame(0, 0, 32'h55555555, 31, 32);
        idle(2);
        chk("coinc_edge_count", 32'(edge_count), ec(16));
        chk("coinc_no_abort", 32'(abort_seen), 32'd1);
        frame(2, 0, 32'hffffffff, -1, 32);
        idle(3);
        chk("coinc_drain", 32'(q.size()), 32'd0);
        chk("coinc2_edge_count", 32'(edge_count), ec(32));

        fs_pulse();
        frame(0, 0, 32'h55555555, -1, 20);
        send(12'hfff, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(1);
        chk_reset_outputs("midrst");
        for (int i = 0; i < 16; i++)
            send(12'hfff, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        idle(2);
        chk("midrst_drain", 32'(q.size()), 32'd0);
        fs_pulse();
        frame(3, 0, 32'h80808080, -1, 32);
        idle(3);
        chk("post_rst_drain", 32'(q.size()), 32'd0);
        chk("post_rst_edge_count", 32'(edge_count), ec(4));
        chk("final_abort_count", 32'(abort_seen), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not reach summary");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/edge_frame_writer.md
Name: edge_frame_writer

Overview:
- Downstream consumer of the Sobel edge stage.
- Takes its 12-bit binarised pixel stream (12'hfff = edge, 12'h000 = no edge) and reduces each pixel to 1 bit.
- Packs PACK_W pixels per word and writes the words sequentially into a single-port edge-map BRAM, one frame per frame_start pulse.
- The VGA read side later scans this BRAM to display the edge map.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- PACK_W, 8, pixels packed per BRAM word. H_ACTIVE must be a multiple of PACK_W.
- ADDR_W, 16, BRAM word address width. Must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE/PACK_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- frame_start  in  1  one-cycle pulse marking start of a new frame
- datain  in  12  binarised pixel from edge stage
- datain_en  in  1  datain valid this cycle
- wr_en  out  1  BRAM write strobe, one cycle per word
- wr_addr  out  ADDR_W  BRAM word address
- wr_data  out  PACK_W  packed pixel bits; pixel k of word at bit k (LSB = leftmost)
- frame_done  out  1  one-cycle pulse, final word of frame written
- frame_abort  out  1  one-cycle pulse, frame_start received mid-frame
- edge_count  out  20  edge pixels in last completed frame (see Optional Feature)

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clk, rst). When rst=0 at a clk edge:
  - state=IDLE; all counters and the pack register cleared.
  - wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_abort=0, edge_count=0.
  - Reset mid-frame discards the partial frame; no write or pulse is issued.
- Pixel bit: bit = |datain (any nonzero value counts as an edge).
- States:
  - IDLE: datain_en is ignored. frame_start moves to RUN.
  - RUN: each datain_en cycle accepts one pixel.
- Priority when frame_start and datain_en are high in the same cycle: that pixel is accepted as pixel 0 of the new frame, from either state.
- Counters in RUN:
  - bit_cnt 0..PACK_W-1 selects the pack register bit.
  - x 0..H_ACTIVE-1 wraps to 0 and increments y.
  - y 0..V_ACTIVE-1.
  - word_addr starts at 0 and increments after each write.
- Word complete: when the pixel at bit_cnt=PACK_W-1 is accepted, the next cycle drives wr_en=1, wr_data = the completed word, wr_addr = word_addr. Latency is 1 clk from the completing datain_en.
- Pixels arriving back-to-back sustain one word every PACK_W cycles with no stall. The block has no backpressure; the BRAM always accepts.
- Last pixel (x=H_ACTIVE-1, y=V_ACTIVE-1):
  - Final word written as above; frame_done=1 in the same cycle as that wr_en.
  - State returns to IDLE on the accepting edge, so further datain_en before the next frame_start is dropped.
  - Final wr_addr = H_ACTIVE*V_ACTIVE/PACK_W-1.
- frame_start in RUN (mid-frame):
  - frame_abort=1 next cycle.
  - Partial pack register discarded, no write for it. Words already written are not rolled back.
  - Counters reset; stays in RUN.
- frame_start in RUN on the same cycle the last pixel is accepted: frame completes normally (frame_done, no abort) and the new frame starts.
- wr_data, wr_addr hold their last values when wr_en=0.

Optional Feature:
- Macro: EDGE_WRITER_COUNT_EN.
- Defined: a 20-bit counter increments for each accepted pixel with bit=1 and clears at frame_start. On the frame_done cycle, edge_count is loaded with the frame total, including the final pixel, and held until the next frame_done or reset. Not updated on abort.
- Undefined: no counter logic; edge_count tied to 0.

Test Plan:
- H_ACTIVE=16, V_ACTIVE=2, PACK_W=8; frame_start, then 32 continuous pixels alternating fff/000 -> 4 writes, addr 0..3, each wr_data=8'h55, frame_done with the addr-3 write; edge_count=16 with macro, 0 without.
- Same params; pixel 0 = fff, rest 000, datain_en toggling every other cycle -> word0=8'h01, words1..3=8'h00, each wr_en 1 clk after the 8th accepted pixel of its word.
- datain_en with pixels before any frame_start -> no wr_en; first write after frame_start still at addr 0.
- frame_start after 12 pixels (mid-word 1) -> frame_abort pulse, 1 write only (addr 0); next full frame writes addr 0..3.
- frame_start coincident with the 32nd pixel -> frame_done, no frame_abort; the following 32 pixels write addr 0..3 again.
- rst=0 for 1 clk after 20 pixels -> all outputs 0 next cycle; subsequent pixels ignored until frame_start.
